// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the video reader, the arbiter and the data RAM.
// slave = arbiter view; master = the surrounding requesters and memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, video bursts are forced in after
// MAX_WAIT denied cycles and then run to completion without preemption.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [AW-1:0] vid_base, base_nxt;
    logic          rd_cpu_q, rd_vid_q;
    logic          cpu_win, vid_win;

    // Decision is purely combinational so the access issues in the same cycle.
    assign cpu_win = (state == ARB) && bus.cpu_req && !(bus.vid_req && (wait_cnt == WAIT_MAX));
    assign vid_win = (state == ARB) && bus.vid_req && !cpu_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            wait_cnt <= '0;
            beat_cnt <= '0;
            vid_base <= '0;
            rd_cpu_q <= 1'b0;
            rd_vid_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat_cnt <= beat_nxt;
            vid_base <= base_nxt;
            rd_cpu_q <= cpu_win && !bus.cpu_we;
            rd_vid_q <= vid_win || (state == BURST);
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        base_nxt  = vid_base;
        case (state)
            ARB: begin
                if (cpu_win) begin
                    if (!bus.vid_req)
                        wait_nxt = '0;
                    else if (wait_cnt != WAIT_MAX)
                        wait_nxt = wait_cnt + 1'b1;
                end else if (vid_win) begin
                    wait_nxt = '0;
                    base_nxt = bus.vid_addr;
                    // Single-beat bursts finish in the grant cycle and never leave ARB.
                    if (BURST_LEN > 1) begin
                        beat_nxt  = BW'(1);
                        state_nxt = BURST;
                    end
                end else begin
                    wait_nxt = '0;
                end
            end
            BURST: begin
                if (beat_cnt == BEAT_LAST) begin
                    beat_nxt  = '0;
                    state_nxt = ARB;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.vid_gnt   = 1'b0;
        bus.cpu_stall = bus.cpu_req;
        case (state)
            ARB: begin
                if (cpu_win) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.cpu_we;
                    bus.mem_addr  = bus.cpu_addr;
                    bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
                    bus.cpu_stall = 1'b0;
                end else if (vid_win) begin
                    bus.vid_gnt  = 1'b1;
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.vid_addr;
                end
            end
            BURST: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = vid_base + AW'(beat_cnt);
            end
            default: ;
        endcase
    end

    assign bus.cpu_rvalid = rd_cpu_q;
    assign bus.vid_rvalid = rd_vid_q;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.vid_rdata  = bus.mem_rdata;
endmodule
